spi_flash_read_seq: RTL

Autonomous read sequencer for the SPI master core. It accepts word-granular flash read requests on a valid/ready port and programs the core's control bundle (command, address, lengths, dummy cycles, chip-select, read strobe), which the APB register block otherwise drives. It streams received words back to the requester with a last flag and recovers from a stalled core with a watchdog-triggered soft reset.

---
 rtl/spi_seq_pkg.sv | 22 ++
 rtl/spi_seq_watchdog.sv | 30 +++
 rtl/spi_flash_read_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI flash read sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_STREAM,
    ST_ABORT,
    ST_ERRBEAT,
    ST_WAIT_IDLE
  } state_t;

  localparam int IDLE_BIT = 0;

  // Word count (1..256, 256 encoded with bit 8 set) to SPI data length in bits.
  function automatic logic [15:0] words_to_bits(input logic [8:0] words);
    return {2'b00, words, 5'b00000};
  endfunction

endpackage

// File: rtl/spi_seq_watchdog.sv
// Idle watchdog: down-counter reloaded on clear, decremented while enabled.
// o_expire is combinational and fires on the TIMEOUT-th consecutive enabled cycle.
module spi_seq_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= LOAD;
    end else if (i_clr) begin
      r_cnt <= LOAD;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_flash_read_seq.sv
// Autonomous flash read sequencer: programs the SPI core bundle, strobes a read and
// streams RX words to the requester (zero-latency pass-through, back-pressure goes to the core).
module spi_flash_read_seq
  import spi_seq_pkg::*;
#(
  parameter int         QUAD         = 0,
  parameter logic [7:0] READ_CMD     = 8'h03,
  parameter int         ADDR_LEN     = 24,
  parameter int         DUMMY_CYCLES = 0,
  parameter logic [7:0] CLK_DIV      = 8'd2,
  parameter int         CS_SEL       = 0,
  parameter int         TIMEOUT      = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_words,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  spi_clk_div,
  output logic        spi_clk_div_valid,
  output logic [31:0] spi_cmd,
  output logic [5:0]  spi_cmd_len,
  output logic [31:0] spi_addr,
  output logic [5:0]  spi_addr_len,
  output logic [15:0] spi_data_len,
  output logic [15:0] spi_dummy_rd,
  output logic [15:0] spi_dummy_wr,
  output logic [3:0]  spi_csreg,
  output logic        spi_rd,
  output logic        spi_qrd,
  output logic        spi_swrst,
  output logic        spi_wr,
  output logic        spi_qwr,
  input  logic [31:0] spi_status,
  input  logic [31:0] spi_data_rx,
  input  logic        spi_data_rx_valid,
  output logic        spi_data_rx_ready
);

  state_t      r_state, w_next;
  logic [8:0]  r_words;
  logic [8:0]  r_cnt;
  logic [7:0]  r_clk_div;
  logic [31:0] r_cmd, r_addr;
  logic [5:0]  r_cmd_len, r_addr_len;
  logic [15:0] r_data_len, r_dummy_rd;
  logic [3:0]  r_csreg;

  logic w_req_hs, w_rsp_hs, w_last, w_expire, w_wd_clr, w_wd_en;
  logic w_unused_status;

  assign w_req_hs = (r_state == ST_IDLE) && req_valid;
  assign w_rsp_hs = (r_state == ST_STREAM) && spi_data_rx_valid && rsp_ready;
  assign w_last   = (r_cnt == (r_words - 9'd1));

  // Back-pressured RX data counts as activity, so a stalled requester never aborts.
  assign w_wd_clr = (r_state != ST_STREAM) || spi_data_rx_valid;
  assign w_wd_en  = (r_state == ST_STREAM) && !spi_data_rx_valid;

  assign w_unused_status = ^spi_status;

  spi_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:      w_next = ST_IDLE;
      ST_IDLE:      if (req_valid) w_next = ST_SETUP;
      ST_SETUP:     w_next = ST_START;
      ST_START:     w_next = ST_STREAM;
      ST_STREAM: begin
        if (w_rsp_hs && w_last) begin
          w_next = ST_WAIT_IDLE;
        end else if (w_expire) begin
          w_next = ST_ABORT;
        end
      end
      ST_ABORT:     w_next = ST_ERRBEAT;
      ST_ERRBEAT:   if (rsp_ready) w_next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (spi_status[IDLE_BIT]) w_next = ST_IDLE;
      default:      w_next = ST_INIT;
    endcase
  end

  // Gating with HRESETn keeps INIT's divider strobe quiet while reset is held.
  always_comb begin
    req_ready         = 1'b0;
    busy              = 1'b0;
    rsp_valid         = 1'b0;
    rsp_data          = '0;
    rsp_last          = 1'b0;
    rsp_err           = 1'b0;
    spi_data_rx_ready = 1'b0;
    spi_clk_div_valid = 1'b0;
    spi_clk_div       = '0;
    spi_rd            = 1'b0;
    spi_qrd           = 1'b0;
    spi_swrst         = 1'b0;
    if (HRESETn) begin
      busy        = (r_state != ST_IDLE);
      spi_clk_div = r_clk_div;
      case (r_state)
        ST_INIT: begin
          spi_clk_div_valid = 1'b1;
          spi_clk_div       = CLK_DIV;
        end
        ST_IDLE:  req_ready = 1'b1;
        ST_START: begin
          spi_rd  = (QUAD == 0);
          spi_qrd = (QUAD != 0);
        end
        ST_STREAM: begin
          rsp_valid         = spi_data_rx_valid;
          rsp_data          = spi_data_rx;
          rsp_last          = w_last;
          spi_data_rx_ready = rsp_ready;
        end
        ST_ABORT: spi_swrst = 1'b1;
        ST_ERRBEAT: begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          rsp_last  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bundle is captured on the accepting edge so it is already stable during SETUP.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_words    <= '0;
      r_cnt      <= '0;
      r_clk_div  <= '0;
      r_cmd      <= '0;
      r_cmd_len  <= '0;
      r_addr     <= '0;
      r_addr_len <= '0;
      r_data_len <= '0;
      r_dummy_rd <= '0;
      r_csreg    <= '0;
    end else begin
      if (r_state == ST_INIT) begin
        r_clk_div <= CLK_DIV;
      end
      if (w_req_hs) begin
        r_words    <= {(req_words == 8'd0), req_words};
        r_cnt      <= '0;
        r_cmd      <= {READ_CMD, 24'h0};
        r_cmd_len  <= 6'd8;
        r_addr     <= req_addr << (32 - ADDR_LEN);
        r_addr_len <= 6'(ADDR_LEN);
        r_data_len <= words_to_bits({(req_words == 8'd0), req_words});
        r_dummy_rd <= 16'(DUMMY_CYCLES);
        r_csreg    <= 4'b0001 << CS_SEL;
      end else if (w_rsp_hs) begin
        r_cnt <= r_cnt + 9'd1;
      end
    end
  end

  assign spi_cmd      = r_cmd;
  assign spi_cmd_len  = r_cmd_len;
  assign spi_addr     = r_addr;
  assign spi_addr_len = r_addr_len;
  assign spi_data_len = r_data_len;
  assign spi_dummy_rd = r_dummy_rd;
  assign spi_dummy_wr = '0;
  assign spi_csreg    = r_csreg;
  assign spi_wr       = 1'b0;
  assign spi_qwr      = 1'b0;

endmodule
